maxpool_window_gen: RTL and testbench
=====================================

# maxpool_window_gen

Streaming front end for the 2x2 max-pool stage. Accepts one feature-map pixel per cycle in raster order, buffers one row, and emits each non-overlapping stride-2 2x2 window as four parallel words `A0..A3` with a one-cycle `en` strobe. Its outputs connect directly to `MaxPool2x2` (`A0..A3`, `en`), so `MaxPool2x2` sees exactly one `en` pulse per pooled output pixel.

## Interface
Parameters:
- `In_W`, 8, pixel width in bits (unsigned).
- `IMG_W`, 28, feature-map width in pixels, 2 or more.
- `IMG_H`, 28, feature-map height in pixels, 2 or more.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` carries a pixel this cycle.
- `in_data`  in  `In_W`  pixel value.
- `A0`  out  `In_W`  window top-left.
- `A1`  out  `In_W`  window top-right.
- `A2`  out  `In_W`  window bottom-left.
- `A3`  out  `In_W`  window bottom-right.
- `en`  out  1  `A0..A3` hold a new window; single-cycle pulse.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters `col` (0..`IMG_W`-1) and `row` (0..`IMG_H`-1) advance only on cycles with `in_valid`=1.
  - `col` wraps to 0 and `row` increments.
  - At (`IMG_H`-1, `IMG_W`-1), both wrap to 0.
- Line buffer: `IMG_W`/2 entries, each 2×`In_W` wide.
  - Even row, odd col: write entry `col`/2 = {previous pixel, `in_data`}.
- Pixel register `prev` captures `in_data` on every accepted pixel.
- Window emit: on an odd row at an odd col, the block registers:
  - `A0` = entry hi
  - `A1` = entry lo
  - `A2` = `prev`
  - `A3` = `in_data`
  - `en` = 1
- Odd `IMG_W`: the last column is consumed but produces no window.
- Odd `IMG_H`: the last row is consumed, not buffered, and produces no window. Pooling output is floor(W/2)×floor(H/2).
- `frame_done` registers 1 when the pixel at (`IMG_H`-1, `IMG_W`-1) is accepted.
- `in_valid`=0 stalls everything. There are no gaps or bubbles inside the window logic, and any stall length is legal.
- Arithmetic is pure data movement. Values pass unchanged, with no sign interpretation.

## Timing
- Reset value, all outputs 0: `A0..A3`=0, `en`=0, `frame_done`=0. Counters and `prev` reset to 0. Line buffer contents are not reset; every entry is rewritten before it is read.
- Latency: `en` rises in the cycle after the clock edge that accepts the bottom-right pixel, which is 1 cycle.
- `en` is high for exactly 1 cycle per window. `A0..A3` hold their last window value until the next emit.
- `en` and `frame_done` pulse in the same cycle when the final pixel completes a window (even W and H).
- `rst` mid-frame: counters return to 0 in the same edge, and the next accepted pixel is (0,0). A window pending on that edge is not emitted.
- `rst` and `in_valid` in the same cycle: reset wins and the pixel is dropped.
- Minimum spacing between `en` pulses is 2 cycles.

## Configuration
- `MAXPOOL_WINGEN_SOF_EN`
  - Defined: adds input port `in_sof` (1 bit). `in_sof`=1 together with `in_valid`=1 forces that pixel to (0,0), regardless of the counters, and processing continues from there. A frame in progress is abandoned, with no `frame_done`.
  - Undefined: the port is absent and frame alignment comes from reset only.

## Structure
- Shared package `maxpool_pkg`:
  - default `In_W`;
  - window index constants (`A0`=top-left … `A3`=bottom-right);
  - `pix_t` typedef.
- Sub-module `wingen_line_buf`:
  - register array of `IMG_W`/2 × 2·`In_W`;
  - one write port, combinational read;
  - write and read never target the same row phase.
- Top contains the counters, `prev`, the emit logic and the output registers.

## Test plan
- `IMG_W`=`IMG_H`=4, pixels 0..15 streamed back-to-back:
  - 4 `en` pulses with (`A0`,`A1`,`A2`,`A3`) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15);
  - `frame_done` pulses together with the last `en`.
- Same stream with `in_valid` low on every other cycle: identical windows, with each `en` 1 cycle after the accepting edge of pixels 5, 7, 13 and 15.
- `IMG_W`=5, `IMG_H`=3, pixels 0..14:
  - exactly 2 windows, (0,1,5,6) and (2,3,7,8);
  - no `en` on row 2;
  - `frame_done` after pixel 14.
- Values 255 and 0 mixed, e.g. (255,0,128,1): passed bit-exact. Chained `MaxPool2x2` outputs 255.
- `rst` asserted after pixel 6 of a 4×4 frame, then pixels 0..15: no spurious `en`; the next 4 windows match scenario 1.
- With `MAXPOOL_WINGEN_SOF_EN`, `in_sof` on a pixel mid-frame then a 4×4 frame: windows are realigned to that pixel and there is no `frame_done` for the abandoned frame.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 max-pool front end.
// Optional feature macro used by this slice: MAXPOOL_WINGEN_SOF_EN (adds in_sof).
package maxpool_pkg;

  // Default pixel width in bits (unsigned data, no sign interpretation).
  localparam int IN_W_DEFAULT = 8;

  // Position of each word inside a 2x2 window.
  localparam int WIN_A0 = 0; // top-left
  localparam int WIN_A1 = 1; // top-right
  localparam int WIN_A2 = 2; // bottom-left
  localparam int WIN_A3 = 3; // bottom-right

  typedef logic [IN_W_DEFAULT-1:0] pix_t;

  // Index width for a counter/array of n positions, never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wingen_line_buf.sv
// One-row line buffer: IMG_W/2 entries, each holding a horizontal pixel pair
// {left, right}. Written on even rows, read on odd rows, so a write and a read
// never target the same row phase and no bypass is needed.
module wingen_line_buf
  import maxpool_pkg::*;
#(
  parameter int In_W  = IN_W_DEFAULT,
  parameter int DEPTH = 14,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [2*In_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [2*In_W-1:0] rd_data_o
);

  // Contents are not reset: every entry is rewritten before it is read.
  logic [2*In_W-1:0] mem_q [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/maxpool_window_gen.sv
// Streaming 2x2 stride-2 window generator feeding MaxPool2x2.
// Pixels arrive in raster order; one row of pixel pairs is buffered and each
// complete window is emitted on A0..A3 with a single-cycle en strobe.
// Optional feature: MAXPOOL_WINGEN_SOF_EN adds in_sof to force a pixel to (0,0).
module maxpool_window_gen
  import maxpool_pkg::*;
#(
  parameter int In_W  = IN_W_DEFAULT,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [In_W-1:0] in_data,
`ifdef MAXPOOL_WINGEN_SOF_EN
  input  logic            in_sof,
`endif
  output logic [In_W-1:0] A0,
  output logic [In_W-1:0] A1,
  output logic [In_W-1:0] A2,
  output logic [In_W-1:0] A3,
  output logic            en,
  output logic            frame_done
);

  localparam int CW    = idx_w(IMG_W);
  localparam int RW    = idx_w(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = idx_w(DEPTH);

  logic [CW-1:0]     col_q, col_d, eff_col;
  logic [RW-1:0]     row_q, row_d, eff_row;
  logic [In_W-1:0]   prev_q, prev_d;
  logic [In_W-1:0]   win_q [4];
  logic [In_W-1:0]   win_d [4];
  logic              en_q, en_d;
  logic              fd_q, fd_d;
  logic              sof;
  logic              last_col, last_row;
  logic              buf_wr;
  logic [AW-1:0]     buf_addr;
  logic [2*In_W-1:0] buf_rd_data;

  // Line buffer; a pixel arriving together with rst is dropped, so no write.
  wingen_line_buf #(
    .In_W  (In_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (buf_wr & ~rst),
    .wr_addr_i (buf_addr),
    .wr_data_i ({prev_q, in_data}),
    .rd_addr_i (buf_addr),
    .rd_data_o (buf_rd_data)
  );

  // Position of the current pixel, counter advance, buffer write and window emit.
  always_comb begin
    sof = 1'b0;
`ifdef MAXPOOL_WINGEN_SOF_EN
    sof = in_sof;
`endif
    eff_col  = sof ? '0 : col_q;
    eff_row  = sof ? '0 : row_q;
    last_col = (eff_col == CW'(IMG_W - 1));
    last_row = (eff_row == RW'(IMG_H - 1));
    buf_addr = AW'(eff_col >> 1);
    buf_wr   = 1'b0;
    col_d    = col_q;
    row_d    = row_q;
    prev_d   = prev_q;
    win_d    = win_q;
    en_d     = 1'b0;
    fd_d     = 1'b0;
    if (in_valid) begin
      prev_d = in_data;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
      // Odd W: the last column is even so never writes or emits.
      // Odd H: the last row is even and is kept out of the buffer.
      buf_wr = ~eff_row[0] & eff_col[0] & ~last_row;
      if (eff_row[0] && eff_col[0]) begin
        win_d[WIN_A0] = buf_rd_data[2*In_W-1:In_W];
        win_d[WIN_A1] = buf_rd_data[In_W-1:0];
        win_d[WIN_A2] = prev_q;
        win_d[WIN_A3] = in_data;
        en_d          = 1'b1;
      end
      fd_d = last_col & last_row;
    end
  end

  // State and output registers; reset wins over an accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      prev_q <= '0;
      win_q  <= '{default: '0};
      en_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      prev_q <= prev_d;
      win_q  <= win_d;
      en_q   <= en_d;
      fd_q   <= fd_d;
    end
  end

  assign A0         = win_q[WIN_A0];
  assign A1         = win_q[WIN_A1];
  assign A2         = win_q[WIN_A2];
  assign A3         = win_q[WIN_A3];
  assign en         = en_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Self-checking bench for maxpool_window_gen: a 4x4 and a 5x3 instance share
// stimulus; a frame-level model predicts every window, en and frame_done.
module tb_maxpool_window_gen;
  import maxpool_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst      = 1'b1;
  logic in_valid = 1'b0;
  pix_t in_data  = '0;
`ifdef MAXPOOL_WINGEN_SOF_EN
  logic in_sof   = 1'b0;
`endif

  pix_t a0_44, a1_44, a2_44, a3_44, a0_53, a1_53, a2_53, a3_53;
  logic en_44, fd_44, en_53, fd_53;

  maxpool_window_gen #(.In_W(8), .IMG_W(4), .IMG_H(4)) u_dut44 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef MAXPOOL_WINGEN_SOF_EN
    .in_sof(in_sof),
`endif
    .A0(a0_44), .A1(a1_44), .A2(a2_44), .A3(a3_44), .en(en_44), .frame_done(fd_44)
  );

  maxpool_window_gen #(.In_W(8), .IMG_W(5), .IMG_H(3)) u_dut53 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef MAXPOOL_WINGEN_SOF_EN
    .in_sof(in_sof),
`endif
    .A0(a0_53), .A1(a1_53), .A2(a2_53), .A3(a3_53), .en(en_53), .frame_done(fd_53)
  );

  // Select which instance is being checked.
  bit          sel = 1'b0;
  logic [31:0] obs_win;
  logic        obs_en, obs_fd;
  always_comb begin
    obs_win = sel ? {a0_53, a1_53, a2_53, a3_53} : {a0_44, a1_44, a2_44, a3_44};
    obs_en  = sel ? en_53 : en_44;
    obs_fd  = sel ? fd_53 : fd_44;
  end

  // ---------------- scoreboard / model ----------------
  int          errors = 0;
  int          checks = 0;
  int          en_seen = 0;
  int          mw = 4, mh = 4, mk = 0;
  logic [7:0]  pix [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_win = '0;

  function automatic logic [7:0] max4(input logic [31:0] w);
    logic [7:0] m;
    m = w[31:24];
    if (w[23:16] > m) m = w[23:16];
    if (w[15:8]  > m) m = w[15:8];
    if (w[7:0]   > m) m = w[7:0];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, advance the frame model at the edge, check.
  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit s);
    int rr, cc;
    bit exp_en, exp_fd;
    rst      = r;
    in_valid = v;
    in_data  = d;
`ifdef MAXPOOL_WINGEN_SOF_EN
    in_sof   = s;
`endif
    @(posedge clk);
    exp_en = 1'b0;
    exp_fd = 1'b0;
    if (r) begin
      mk = 0;
      last_win = '0;
      exp_q.delete();
    end else if (v) begin
      if (s) mk = 0;
      rr = mk / mw;
      cc = mk % mw;
      pix[mk] = d;
      if ((rr % 2 == 1) && (cc % 2 == 1)) begin
        exp_q.push_back({pix[mk-mw-1], pix[mk-mw], pix[mk-1], d});
        exp_en = 1'b1;
      end
      if (mk == mw * mh - 1) exp_fd = 1'b1;
      mk = (mk + 1) % (mw * mh);
    end
    #1;
    if (exp_en) last_win = exp_q.pop_front();
    if (obs_en === 1'b1) en_seen++;
    chk("en", {31'd0, obs_en}, {31'd0, exp_en});
    chk("frame_done", {31'd0, obs_fd}, {31'd0, exp_fd});
    chk("window", obs_win, last_win);
    if (exp_en) chk("pool_max", {24'd0, max4(obs_win)}, {24'd0, max4(last_win)});
  endtask

  task automatic select(input bit s, input int w, input int h);
    sel = s;
    mw  = w;
    mh  = h;
    step(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] mix [16];

  initial begin
    mix = '{8'd255, 8'd0, 8'd7, 8'd200, 8'd128, 8'd1, 8'd0, 8'd255,
            8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd128, 8'd127};

    // Reset state: all outputs zero (both instances).
    select(1'b0, 4, 4);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("reset_53", {a0_53, a1_53, a2_53, a3_53}, 32'd0);
    chk("reset_53_flags", {30'd0, en_53, fd_53}, 32'd0);

    // 4x4, pixels 0..15 back-to-back.
    en_seen = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("en_count_4x4", en_seen, 4);

    // Same stream with a bubble after every pixel.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    // Extreme values passed bit-exact; first window (255,0,128,1).
    for (int i = 0; i < 16; i++) step(1'b1, mix[i], 1'b0, 1'b0);

    // Reset mid-frame after pixel 6, with pixel 7 offered on the reset edge.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'd7, 1'b1, 1'b0);
    en_seen = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("en_count_after_rst", en_seen, 4);

    // Random data and random stalls, 3 frames.
    for (int n = 0; n < 48; n++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom), 1'b0, 1'b0);
    end
    step(1'b0, 8'd0, 1'b0, 1'b0);

    // 5x3: odd width and height.
    select(1'b1, 5, 3);
    en_seen = 0;
    for (int i = 0; i < 15; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("en_count_5x3", en_seen, 2);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, 8'd0, 1'b0, 1'b0);
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    step(1'b0, 8'd0, 1'b0, 1'b0);

`ifdef MAXPOOL_WINGEN_SOF_EN
    // Start-of-frame mid-frame realigns; the abandoned frame gives no frame_done.
    select(1'b0, 4, 4);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(100 + i), 1'b0, 1'b0);
    en_seen = 0;
    step(1'b1, 8'd0, 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("en_count_sof", en_seen, 4);
`endif

    chk("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
